// File: rtl/cpu_pkg.sv
// Shared constants for the GPR/ALU execution sequencer: opcodes, IR field
// positions, FSM state encodings and flag bit indices.
package cpu_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned INSTR_W = 32;

    localparam logic [OP_W-1:0] OP_MOVSGPR = 5'd0;
    localparam logic [OP_W-1:0] OP_MOV     = 5'd1;
    localparam logic [OP_W-1:0] OP_ADD     = 5'd2;
    localparam logic [OP_W-1:0] OP_SUB     = 5'd3;
    localparam logic [OP_W-1:0] OP_MUL     = 5'd4;
    localparam logic [OP_W-1:0] OP_HALT    = 5'b11111;

    // LSB position of each IR field
    localparam int unsigned OP_LSB    = 27;
    localparam int unsigned RDST_LSB  = 22;
    localparam int unsigned RSRC1_LSB = 17;
    localparam int unsigned IMM_BIT   = 16;
    localparam int unsigned RSRC2_LSB = 11;
    localparam int unsigned ISRC_LSB  = 0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    // flags = {sign, zero, overflow, carry}
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_S = 3;

endpackage

// File: rtl/ir_decode.sv
// Combinational IR splitter: field extraction, operand-B select and op class.
module ir_decode
    import cpu_pkg::*;
#(
    parameter logic [OP_W-1:0] HALT_OP = OP_HALT
) (
    input  logic [INSTR_W-1:0] i_ir,
    input  logic [DATA_W-1:0]  i_rf_rdata2,
    output logic [OP_W-1:0]    o_op_c,
    output logic [REG_AW-1:0]  o_rdst_c,
    output logic [REG_AW-1:0]  o_rsrc1_c,
    output logic [REG_AW-1:0]  o_rsrc2_c,
    output logic               o_imm_c,
    output logic [DATA_W-1:0]  o_isrc_c,
    output logic [DATA_W-1:0]  o_opb_c,
    output logic               o_is_alu_c,
    output logic               o_is_move_c,
    output logic               o_is_halt_c,
    output logic               o_is_illegal_c
);

    assign o_op_c    = i_ir[OP_LSB    +: OP_W];
    assign o_rdst_c  = i_ir[RDST_LSB  +: REG_AW];
    assign o_rsrc1_c = i_ir[RSRC1_LSB +: REG_AW];
    assign o_rsrc2_c = i_ir[RSRC2_LSB +: REG_AW];
    assign o_imm_c   = i_ir[IMM_BIT];
    assign o_isrc_c  = i_ir[ISRC_LSB  +: DATA_W];

    assign o_opb_c = o_imm_c ? o_isrc_c : i_rf_rdata2;

    // halt has priority so a HALT_OP overlapping a real opcode still stops
    always_comb begin
        o_is_halt_c    = 1'b0;
        o_is_alu_c     = 1'b0;
        o_is_move_c    = 1'b0;
        o_is_illegal_c = 1'b0;
        if (o_op_c == HALT_OP) begin
            o_is_halt_c = 1'b1;
        end else if (o_op_c == OP_ADD || o_op_c == OP_SUB || o_op_c == OP_MUL) begin
            o_is_alu_c = 1'b1;
        end else if (o_op_c == OP_MOVSGPR || o_op_c == OP_MOV) begin
            o_is_move_c = 1'b1;
        end else begin
            o_is_illegal_c = 1'b1;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit GPR/ALU
// datapath. Owns PC, IR, flags and halt/illegal status.
module exec_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [OP_W-1:0]   HALT_OP  = OP_HALT
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               start,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [REG_AW-1:0]  rf_raddr1,
    output logic [REG_AW-1:0]  rf_raddr2,
    input  logic [DATA_W-1:0]  rf_rdata1,
    input  logic [DATA_W-1:0]  rf_rdata2,
    output logic               rf_we,
    output logic [REG_AW-1:0]  rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    input  logic [DATA_W-1:0]  sgpr_rdata,
    output logic               sgpr_we,
    output logic [DATA_W-1:0]  sgpr_wdata,
    output logic               alu_start,
    output logic [OP_W-1:0]    alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic               alu_done,
    input  logic [2*DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0]  alu_flags,
    output logic [FLAG_W-1:0]  flags,
    output logic               retired,
    output logic               busy,
    output logic               halted,
    output logic               illegal
);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nx;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [FLAG_W-1:0]  r_flags;
    logic               r_illegal;
    logic               r_imem_req;
    logic               r_rf_we;
    logic [REG_AW-1:0]  r_rf_waddr;
    logic [DATA_W-1:0]  r_rf_wdata;
    logic               r_sgpr_we;
    logic [DATA_W-1:0]  r_sgpr_wdata;
    logic               r_alu_start;
    logic [OP_W-1:0]    r_alu_op;
    logic [DATA_W-1:0]  r_alu_a;
    logic [DATA_W-1:0]  r_alu_b;
    logic               r_retired;
    logic               r_busy;
    logic               r_halted;

    logic [OP_W-1:0]    w_op;
    logic [REG_AW-1:0]  w_rdst;
    logic [REG_AW-1:0]  w_rsrc1;
    logic [REG_AW-1:0]  w_rsrc2;
    logic               w_imm;
    logic [DATA_W-1:0]  w_isrc;
    logic [DATA_W-1:0]  w_opb;
    logic               w_is_alu;
    logic               w_is_move;
    logic               w_is_halt;
    logic               w_is_illegal;

    ir_decode #(.HALT_OP(HALT_OP)) u_ir_decode (
        .i_ir           (r_ir),
        .i_rf_rdata2    (rf_rdata2),
        .o_op_c         (w_op),
        .o_rdst_c       (w_rdst),
        .o_rsrc1_c      (w_rsrc1),
        .o_rsrc2_c      (w_rsrc2),
        .o_imm_c        (w_imm),
        .o_isrc_c       (w_isrc),
        .o_opb_c        (w_opb),
        .o_is_alu_c     (w_is_alu),
        .o_is_move_c    (w_is_move),
        .o_is_halt_c    (w_is_halt),
        .o_is_illegal_c (w_is_illegal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nx = S_FETCH;
            S_FETCH:  if (imem_valid) w_state_nx = S_DECODE;
            S_DECODE: w_state_nx = S_EXEC;
            S_EXEC: begin
                if (w_is_halt) begin
                    w_state_nx = S_HALT;
                end else if (w_is_alu) begin
                    w_state_nx = S_WAIT;
                end else begin
                    w_state_nx = S_WB;
                end
            end
            S_WAIT:   if (alu_done) w_state_nx = S_WB;
            S_WB:     w_state_nx = S_FETCH;
            S_HALT:   w_state_nx = S_HALT;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // Datapath and registered outputs, keyed off the state being entered
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_flags      <= '0;
            r_illegal    <= 1'b0;
            r_imem_req   <= 1'b0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_sgpr_we    <= 1'b0;
            r_sgpr_wdata <= '0;
            r_alu_start  <= 1'b0;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_retired    <= 1'b0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_imem_req  <= (w_state_nx == S_FETCH);
            r_alu_start <= (r_state == S_DECODE) && w_is_alu;
            r_rf_we     <= (w_state_nx == S_WB);
            r_retired   <= (w_state_nx == S_WB);
            r_sgpr_we   <= (r_state == S_WAIT) && alu_done && (r_alu_op == OP_MUL);
            r_busy      <= (w_state_nx != S_IDLE) && (w_state_nx != S_HALT);
            r_halted    <= (w_state_nx == S_HALT);

            if (r_state == S_IDLE && start) begin
                r_pc <= RESET_PC;
            end
            if (r_state == S_FETCH && imem_valid) begin
                r_ir <= imem_data;
                r_pc <= r_pc + ADDR_W'(1);
            end
            if (r_state == S_DECODE) begin
                r_alu_op <= w_op;
                r_alu_a  <= rf_rdata1;
                r_alu_b  <= w_opb;
            end
            // moves resolve here; illegal writes 0; ALU ops overwrite on done
            if (r_state == S_EXEC) begin
                if (w_is_illegal) begin
                    r_illegal <= 1'b1;
                end
                if (w_is_move) begin
                    r_rf_wdata <= (w_op == OP_MOVSGPR) ? sgpr_rdata
                                : (w_imm ? w_isrc : rf_rdata1);
                end else begin
                    r_rf_wdata <= '0;
                end
            end
            if (r_state == S_WAIT && alu_done) begin
                r_rf_wdata <= alu_result[DATA_W-1:0];
                if (r_alu_op == OP_MUL) begin
                    r_sgpr_wdata <= alu_result[2*DATA_W-1:DATA_W];
                end
                r_flags[FLAG_S] <= alu_flags[FLAG_S];
                r_flags[FLAG_Z] <= alu_flags[FLAG_Z];
                r_flags[FLAG_V] <= alu_flags[FLAG_V];
                r_flags[FLAG_C] <= alu_flags[FLAG_C];
            end
            if (w_state_nx == S_WB) begin
                r_rf_waddr <= w_rdst;
            end
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign rf_raddr1  = w_rsrc1;
    assign rf_raddr2  = w_rsrc2;
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign sgpr_we    = r_sgpr_we;
    assign sgpr_wdata = r_sgpr_wdata;
    assign alu_start  = r_alu_start;
    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign flags      = r_flags;
    assign retired    = r_retired;
    assign busy       = r_busy;
    assign halted     = r_halted;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer with imem, register file,
// SGPR and ALU behavioural responders.
module tb_exec_sequencer;
    import cpu_pkg::*;

    localparam int unsigned ADDR_W = 16;

    logic                clk = 1'b0;
    logic                sys_rst;
    logic                start;
    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_valid;
    logic [31:0]         imem_data;
    logic [4:0]          rf_raddr1, rf_raddr2;
    logic [15:0]         rf_rdata1, rf_rdata2;
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [15:0]         rf_wdata;
    logic [15:0]         sgpr_rdata;
    logic                sgpr_we;
    logic [15:0]         sgpr_wdata;
    logic                alu_start;
    logic [4:0]          alu_op;
    logic [15:0]         alu_a, alu_b;
    logic                alu_done;
    logic [31:0]         alu_result;
    logic [3:0]          alu_flags;
    logic [3:0]          flags;
    logic                retired, busy, halted, illegal;

    always #5 clk = ~clk;

    exec_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000), .HALT_OP(5'b11111)) dut (
        .clk(clk), .sys_rst(sys_rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sgpr_rdata(sgpr_rdata), .sgpr_we(sgpr_we), .sgpr_wdata(sgpr_wdata),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
        .flags(flags), .retired(retired), .busy(busy), .halted(halted), .illegal(illegal)
    );

    // instruction memory with a per-address response delay
    logic [31:0]       imem [16];
    logic [ADDR_W-1:0] dly_addr = '0;
    int unsigned       dly_n = 0;
    int unsigned       fwait = 0;
    assign imem_valid = imem_req && (fwait >= ((imem_addr == dly_addr) ? dly_n : 32'd0));
    assign imem_data  = imem_req ? imem[imem_addr[3:0]] : 32'h0;
    always @(posedge clk) fwait <= (imem_req && !imem_valid) ? fwait + 1 : 0;

    logic [15:0] rf [32];
    logic [15:0] sgpr;
    always @(posedge clk) begin
        if (sys_rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 16'h0;
            sgpr <= 16'h0;
        end else begin
            if (rf_we) rf[rf_waddr] <= rf_wdata;
            if (sgpr_we) sgpr <= sgpr_wdata;
        end
    end
    assign rf_rdata1  = rf[rf_raddr1];
    assign rf_rdata2  = rf[rf_raddr2];
    assign sgpr_rdata = sgpr;

    // ALU responder: result after alu_lat cycles; deliberately ignores sys_rst
    function automatic logic [35:0] alu_model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [31:0] r;
        logic        c, v;
        s = 17'h0; r = 32'h0; c = 1'b0; v = 1'b0;
        case (op)
            5'd2: begin s = {1'b0, a} + {1'b0, b}; r = {16'h0, s[15:0]}; c = s[16];
                        v = (a[15] == b[15]) && (s[15] != a[15]); end
            5'd3: begin s = {1'b0, a} - {1'b0, b}; r = {16'h0, s[15:0]}; c = s[16];
                        v = (a[15] != b[15]) && (s[15] != a[15]); end
            5'd4: r = 32'(a) * 32'(b);
            default: r = 32'h0;
        endcase
        return {r, r[15], (r[15:0] == 16'h0), v, c};
    endfunction

    int unsigned alu_lat = 1;
    int unsigned alu_cnt = 0;
    always @(posedge clk) begin
        if (alu_start) begin
            alu_cnt <= alu_lat;
            {alu_result, alu_flags} <= alu_model(alu_op, alu_a, alu_b);
        end else if (alu_cnt != 0) begin
            alu_cnt <= alu_cnt - 1;
        end
    end
    assign alu_done = (alu_cnt == 1);

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    logic [4:0]  wr_addr [$];
    logic [15:0] wr_data [$];
    logic [15:0] ret_pc [$];
    logic [3:0]  ret_flags [$];
    int ret_cnt, sgpr_cnt, first_req, first_ret, trace_req, trace_valid, trace_drift, ret_in_req, alu_done_seen;
    logic [15:0] sgpr_last;
    logic [4:0]  sgpr_wb_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); ret_pc.delete(); ret_flags.delete();
        ret_cnt = 0; sgpr_cnt = 0; first_req = -1; first_ret = -1;
        trace_req = 0; trace_valid = 0; trace_drift = 0; ret_in_req = 0; alu_done_seen = 0;
        sgpr_last = 16'h0; sgpr_wb_addr = 5'h0;
    endtask

    // advance one cycle and log DUT activity at the negative edge
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rf_we) begin wr_addr.push_back(rf_waddr); wr_data.push_back(rf_wdata); end
        if (sgpr_we) begin
            sgpr_cnt++; sgpr_last = sgpr_wdata;
            sgpr_wb_addr = rf_we ? rf_waddr : 5'h1f;
        end
        if (retired) begin
            ret_cnt++; ret_pc.push_back(imem_addr); ret_flags.push_back(flags);
            if (first_ret < 0) first_ret = cyc;
        end
        if (imem_req && first_req < 0) first_req = cyc;
        if (imem_req && retired) ret_in_req++;
        if (alu_done) alu_done_seen++;
        if (dly_n != 0 && imem_req && imem_addr == dly_addr) begin
            trace_req++;
            if (imem_valid) trace_valid++;
            if (rf_raddr1 != 5'd1) trace_drift++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic run_halt(input int budget);
        int k = 0;
        while (!halted && k < budget) begin tick(); k++; end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_imem_req"},  32'(imem_req),  32'd0);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_rf_we"},     32'(rf_we),     32'd0);
        chk({tag, "_rf_waddr"},  32'(rf_waddr),  32'd0);
        chk({tag, "_rf_wdata"},  32'(rf_wdata),  32'd0);
        chk({tag, "_rf_raddr1"}, 32'(rf_raddr1), 32'd0);
        chk({tag, "_sgpr_we"},   32'(sgpr_we),   32'd0);
        chk({tag, "_sgpr_wd"},   32'(sgpr_wdata), 32'd0);
        chk({tag, "_alu_start"}, 32'(alu_start), 32'd0);
        chk({tag, "_alu_opab"},  {11'h0, alu_op, alu_a} | 32'(alu_b), 32'd0);
        chk({tag, "_flags"},     32'(flags),     32'd0);
        chk({tag, "_retired"},   32'(retired),   32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_halted"},    32'(halted),    32'd0);
        chk({tag, "_illegal"},   32'(illegal),   32'd0);
    endtask

    initial begin
        sys_rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 16; i++) imem[i] = 32'hF800_0000;
        // program A: mov r1,#5; add r2,r1,#3; sub r3,r1,#5; illegal r4; halt
        imem[0] = 32'h0841_0005; imem[1] = 32'h1083_0003; imem[2] = 32'h18C3_0005;
        imem[3] = 32'h5100_0000; imem[4] = 32'hF800_0000;
        clear_log();
        tick(); tick();
        reset_checks("rst0");
        sys_rst = 1'b0;
        tick();
        chk("idle_wait_busy", 32'(busy), 32'd0);

        alu_lat = 1;
        clear_log();
        pulse_start();
        run_halt(100);
        chk("A_mov_latency", 32'(first_ret - first_req), 32'd3);
        chk("A_nwrites", 32'(wr_addr.size()), 32'd4);
        chk("A_w0", {wr_addr[0], wr_data[0]}, {5'd1, 16'h0005});
        chk("A_w1", {wr_addr[1], wr_data[1]}, {5'd2, 16'h0008});
        chk("A_w2", {wr_addr[2], wr_data[2]}, {5'd3, 16'h0000});
        chk("A_w3_illegal", {wr_addr[3], wr_data[3]}, {5'd4, 16'h0000});
        chk("A_retired", 32'(ret_cnt), 32'd4);
        chk("A_pc_after_add", 32'(ret_pc[1]), 32'd2);
        chk("A_flags_add", 32'(ret_flags[1]), 32'h0);
        chk("A_flags_sub", 32'(ret_flags[2]), 32'h4);
        chk("A_flags_illegal_kept", 32'(ret_flags[3]), 32'h4);
        chk("A_illegal_sticky", 32'(illegal), 32'd1);
        chk("A_busy_halt", 32'(busy), 32'd0);
        chk("A_pc_halt", 32'(imem_addr), 32'd5);
        chk("A_no_sgpr", 32'(sgpr_cnt), 32'd0);

        clear_log();
        pulse_start();
        repeat (5) tick();
        chk("halt_no_req", 32'(first_req), 32'hFFFF_FFFF);
        chk("halt_start_ignored", 32'(halted), 32'd1);
        chk("halt_pc_kept", 32'(imem_addr), 32'd5);

        sys_rst = 1'b1;
        tick(); tick();
        reset_checks("rst1");
        sys_rst = 1'b0;

        // program B: mov r1,#0x1234; mov r2,#0x100; mul r3,r1,r2; mov r6,#1 (slow fetch); halt
        imem[0] = 32'h0841_1234; imem[1] = 32'h0881_0100; imem[2] = 32'h20C2_1000;
        imem[3] = 32'h0981_0001; imem[4] = 32'hF800_0000;
        dly_addr = 16'd3; dly_n = 3; alu_lat = 2;
        clear_log();
        pulse_start();
        run_halt(100);
        chk("B_nwrites", 32'(wr_addr.size()), 32'd4);
        chk("B_w0", {wr_addr[0], wr_data[0]}, {5'd1, 16'h1234});
        chk("B_w1", {wr_addr[1], wr_data[1]}, {5'd2, 16'h0100});
        chk("B_mul_lo", {wr_addr[2], wr_data[2]}, {5'd3, 16'h3400});
        chk("B_w3", {wr_addr[3], wr_data[3]}, {5'd6, 16'h0001});
        chk("B_sgpr_cnt", 32'(sgpr_cnt), 32'd1);
        chk("B_sgpr_hi", 32'(sgpr_last), 32'h0012);
        chk("B_sgpr_same_wb", 32'(sgpr_wb_addr), 32'd3);
        chk("B_fetch_hold", 32'(trace_req), 32'd4);
        chk("B_fetch_valid", 32'(trace_valid), 32'd1);
        chk("B_ir_not_early", 32'(trace_drift), 32'd0);
        chk("B_no_retire_in_fetch", 32'(ret_in_req), 32'd0);
        chk("B_retired", 32'(ret_cnt), 32'd4);
        chk("B_illegal_clear", 32'(illegal), 32'd0);

        // reset while waiting on a slow ALU op
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        imem[0] = 32'h1041_0001;
        dly_n = 0; alu_lat = 8;
        clear_log();
        pulse_start();
        begin
            int k = 0;
            while (!alu_start && k < 10) begin tick(); k++; end
        end
        chk("C_alu_launched", 32'(alu_start), 32'd1);
        tick(); tick();
        chk("C_in_wait", 32'(busy), 32'd1);
        clear_log();
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        repeat (12) tick();
        chk("C_late_done_seen", 32'(alu_done_seen), 32'd1);
        chk("C_no_rf_we", 32'(wr_addr.size()), 32'd0);
        chk("C_no_sgpr_we", 32'(sgpr_cnt), 32'd0);
        chk("C_no_retire", 32'(ret_cnt), 32'd0);
        reset_checks("C_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit GPR/ALU datapath.
- Fetches 32-bit instructions from instruction memory via a req/valid handshake and decodes the IR fields.
- Sequences the external register file, the SGPR and the ALU (single- and multi-cycle ops), then retires one instruction at a time.
- Sits between imem and the datapath; owns PC, IR, the flag register and halt/illegal status.

Parameters:
- ADDR_W, 16: PC / imem address width.
- RESET_PC, 0: PC value after reset and on start.
- HALT_OP, 5'b11111: opcode that stops the sequencer.

Ports:
- clk  in  1  clock
- sys_rst  in  1  synchronous active-high reset
- start  in  1  begin execution from RESET_PC; honoured only in IDLE
- imem_req  out  1  fetch request, held until imem_valid
- imem_addr  out  ADDR_W  fetch address (= PC)
- imem_valid  in  1  instruction data valid
- imem_data  in  32  instruction word
- rf_raddr1 / rf_raddr2  out  5  register-file read addresses (combinational read)
- rf_rdata1 / rf_rdata2  in  16  read data
- rf_we  out  1  GPR write enable
- rf_waddr  out  5  GPR write address
- rf_wdata  out  16  GPR write data
- sgpr_rdata  in  16  current SGPR value
- sgpr_we  out  1  SGPR write enable
- sgpr_wdata  out  16  SGPR write data
- alu_start  out  1  one-cycle ALU launch pulse
- alu_op  out  5  opcode to ALU
- alu_a / alu_b  out  16  operands
- alu_done  in  1  ALU result valid; never asserted in the same cycle as alu_start
- alu_result  in  32  ALU result (upper half meaningful for mul only)
- alu_flags  in  4  {sign, zero, overflow, carry}
- flags  out  4  latched flags of the last retired ALU op
- retired  out  1  one-cycle pulse per retired instruction
- busy  out  1  high in any state except IDLE and HALT
- halted  out  1  high in HALT
- illegal  out  1  sticky; set on an unsupported opcode

Behaviour:
- Reset: state=IDLE, PC=RESET_PC, IR=0, flags=0, illegal=0. All strobes (imem_req, rf_we, sgpr_we, alu_start, retired) are 0, and all data outputs are 0.
- Reset mid-operation has the same effect. Any pending imem or ALU response is ignored.
- IR fields:
  - op = [31:27], rdst = [26:22], rsrc1 = [21:17], imm = [16], rsrc2 = [15:11], isrc = [15:0].
  - Opcodes: movsgpr = 0, mov = 1, add = 2, sub = 3, mul = 4.
- IDLE: on start go to FETCH, with PC=RESET_PC.
- FETCH:
  - imem_req=1 and imem_addr=PC, held for every cycle until imem_valid.
  - imem_valid may arrive in the first FETCH cycle.
  - On imem_valid: IR<=imem_data, PC<=PC+1 (wraps modulo 2^ADDR_W), go to DECODE.
- DECODE (1 cycle):
  - rf_raddr1=rsrc1 and rf_raddr2=rsrc2, held through EXEC.
  - Operand B = imm ? isrc : rf_rdata2.
- EXEC (1 cycle):
  - op == HALT_OP: go to HALT (not retired).
  - op in {add, sub, mul}: alu_start=1 with alu_op/alu_a/alu_b valid, go to WAIT.
  - op in {movsgpr, mov}: no ALU launch, go to WB.
  - op unsupported: set illegal, go to WB with write data 0.
- WAIT: hold alu_op/alu_a/alu_b; no timeout. On alu_done, capture alu_result and alu_flags, go to WB.
- WB (1 cycle):
  - rf_we=1 and rf_waddr=rdst.
  - rf_wdata:
    - movsgpr: sgpr_rdata
    - mov: imm ? isrc : rf_rdata1
    - add/sub/mul: alu_result[15:0]
    - illegal: 0
  - mul only: sgpr_we=1 and sgpr_wdata=alu_result[31:16].
  - flags updated only for add/sub/mul; mov, movsgpr and illegal leave flags unchanged.
  - retired=1, then return to FETCH.
- HALT: all strobes 0. Exit only via sys_rst. start is ignored.
- start in any state other than IDLE is ignored.
- Latency (imem_valid in the first FETCH cycle): mov/movsgpr take 4 cycles fetch-to-retire; ALU ops take 4 + (cycles until alu_done) cycles.

Decomposition:
- Shared package `cpu_pkg`:
  - opcode constants (movsgpr..mul, HALT_OP)
  - IR field slice positions
  - state enum {IDLE, FETCH, DECODE, EXEC, WAIT, WB, HALT}
  - flag bit indices
- One natural sub-module: `ir_decode`. Combinational; splits the IR into fields, computes operand B, and classifies the op as alu / move / halt / illegal.

Test Plan:
- Program mov r1,#5; add r2,r1,#3 (alu_done 1 cycle after start) -> rf writes r1=5 then r2=8; flags zero=0, sign=0; two retired pulses; PC=2.
- mul r3,r1,r2 with r1=0x1234, r2=0x0100 -> rf_wdata=0x3400 to r3; sgpr_wdata=0x0012 with sgpr_we pulsed once in the same WB cycle.
- imem_valid delayed 3 cycles -> imem_req and imem_addr held stable for 4 cycles; IR captured only on valid; no early retire.
- Opcode 5'b01010 -> illegal=1 (sticky); r[rdst] written 0; flags unchanged; execution continues at the next PC.
- HALT_OP at PC=4 -> halted=1 and busy=0; no further imem_req; start ignored; sys_rst returns to IDLE with PC=0 and halted=0.
- sys_rst asserted in WAIT, then alu_done arrives later -> no rf_we/sgpr_we/retired; state IDLE and all outputs at reset values.
